// File: rtl/tdm_demux4_pkg.sv
// Shared types for the 1-to-4 TDM demultiplexer: FSM states, slot index and channel count.
package tdm_demux_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {HUNT, LOCKED} demux_state_t;

  typedef logic [1:0] slot_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Bus bundle between the sender of the shared line and the demultiplexer.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);
  import tdm_demux_pkg::*;

  logic [WIDTH-1:0]  f;
  logic              f_valid;
  logic              frame_sync;
  logic              mode;
  logic              s1;
  logic              s2;
  logic [WIDTH-1:0]  x1;
  logic [WIDTH-1:0]  x2;
  logic [WIDTH-1:0]  x3;
  logic [WIDTH-1:0]  x4;
  logic [NUM_CH-1:0] x_valid;
  logic              frame_done;
  logic              sync_err;

  modport master (
    output f, f_valid, frame_sync, mode, s1, s2,
    input  x1, x2, x3, x4, x_valid, frame_done, sync_err
  );

  modport slave (
    input  f, f_valid, frame_sync, mode, s1, s2,
    output x1, x2, x3, x4, x_valid, frame_done, sync_err
  );

endinterface

// File: rtl/tdm_demux4_slot_ctrl.sv
// Slot controller: decides which channel (if any) the current sample goes to,
// tracks frame alignment in TDM mode and raises the registered frame/sync pulses.
module tdm_slot_ctrl
  import tdm_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  f_valid,
  input  logic  frame_sync,
  input  logic  mode,
  input  logic  s1,
  input  logic  s2,
  output logic  wr_en,
  output slot_t wr_slot,
  output logic  frame_done,
  output logic  sync_err
);

  demux_state_t state, state_nxt;
  slot_t        slot, slot_nxt;
  logic         frame_done_nxt;
  logic         sync_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      slot       <= slot_nxt;
      frame_done <= frame_done_nxt;
      sync_err   <= sync_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    slot_nxt       = slot;
    wr_en          = 1'b0;
    wr_slot        = slot;
    frame_done_nxt = 1'b0;
    sync_err_nxt   = 1'b0;

    if (mode) begin
      // Direct select keeps the TDM side parked so returning to TDM starts by hunting.
      state_nxt = HUNT;
      slot_nxt  = '0;
      wr_en     = f_valid;
      wr_slot   = {s2, s1};
    end else if (f_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            wr_en     = 1'b1;
            wr_slot   = '0;
            slot_nxt  = 2'd1;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (slot == 2'd0 && !frame_sync) begin
            sync_err_nxt = 1'b1;
            slot_nxt     = '0;
            state_nxt    = HUNT;
          end else if (slot != 2'd0 && frame_sync) begin
            // Early sync realigns on the new frame without completing the old one.
            sync_err_nxt = 1'b1;
            wr_en        = 1'b1;
            wr_slot      = '0;
            slot_nxt     = 2'd1;
          end else begin
            wr_en          = 1'b1;
            wr_slot        = slot;
            slot_nxt       = slot_t'(slot + 2'd1);
            frame_done_nxt = (slot == 2'd3);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Registered 1-to-4 demultiplexer: four hold registers fed from the shared line,
// steered by the slot controller in either TDM or direct-select mode.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst,
  tdm_demux4_if.slave bus
);

  logic             wr_en;
  slot_t            wr_slot;
  logic [WIDTH-1:0] ch [NUM_CH];
  logic [NUM_CH-1:0] x_valid;

  tdm_slot_ctrl u_slot_ctrl (
    .clk        (clk),
    .rst        (rst),
    .f_valid    (bus.f_valid),
    .frame_sync (bus.frame_sync),
    .mode       (bus.mode),
    .s1         (bus.s1),
    .s2         (bus.s2),
    .wr_en      (wr_en),
    .wr_slot    (wr_slot),
    .frame_done (bus.frame_done),
    .sync_err   (bus.sync_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) ch[i] <= '0;
      x_valid <= '0;
    end else begin
      x_valid <= '0;
      if (wr_en) begin
        ch[wr_slot]      <= bus.f;
        x_valid[wr_slot] <= 1'b1;
      end
    end
  end

  assign bus.x1      = ch[0];
  assign bus.x2      = ch[1];
  assign bus.x3      = ch[2];
  assign bus.x4      = ch[3];
  assign bus.x_valid = x_valid;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (WIDTH=8): per-cycle vectors with hand-derived
// expected outputs, queued as a scoreboard and compared one cycle after the drive edge.
module tb_tdm_demux4;

  localparam int W = 8;

  typedef struct packed {
    logic         rst;
    logic         mode;
    logic         fv;
    logic         fs;
    logic [1:0]   sel;
    logic [W-1:0] f;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    logic [W-1:0] e3;
    logic [W-1:0] e4;
    logic [3:0]   ev;
    logic         efd;
    logic         ese;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  int compared   = 0;
  int mismatched = 0;
  int vec_no     = 0;

  vec_t exp_q[$];
  vec_t table_v[$];

  tdm_demux4_if #(.WIDTH(W)) bus ();

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic m, input logic fv, input logic fs,
                              input logic [1:0] sel, input logic [W-1:0] f,
                              input logic [W-1:0] e1, input logic [W-1:0] e2,
                              input logic [W-1:0] e3, input logic [W-1:0] e4,
                              input logic [3:0] ev, input logic efd, input logic ese);
    vec_t v;
    v.rst = r;  v.mode = m;  v.fv = fv;  v.fs = fs;  v.sel = sel;  v.f = f;
    v.e1 = e1;  v.e2 = e2;   v.e3 = e3;  v.e4 = e4;
    v.ev = ev;  v.efd = efd; v.ese = ese;
    return v;
  endfunction

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: got empty queue, want an expected entry");
      return;
    end
    e = exp_q.pop_front();
    compared++;
    if ({bus.x1, bus.x2, bus.x3, bus.x4} !== {e.e1, e.e2, e.e3, e.e4}) begin
      mismatched++;
      $display("[TB] FAIL vec%0d x1..x4: got %h %h %h %h want %h %h %h %h", vec_no,
               bus.x1, bus.x2, bus.x3, bus.x4, e.e1, e.e2, e.e3, e.e4);
    end
    compared++;
    if (bus.x_valid !== e.ev) begin
      mismatched++;
      $display("[TB] FAIL vec%0d x_valid: got %b want %b", vec_no, bus.x_valid, e.ev);
    end
    compared++;
    if (bus.frame_done !== e.efd) begin
      mismatched++;
      $display("[TB] FAIL vec%0d frame_done: got %b want %b", vec_no, bus.frame_done, e.efd);
    end
    compared++;
    if (bus.sync_err !== e.ese) begin
      mismatched++;
      $display("[TB] FAIL vec%0d sync_err: got %b want %b", vec_no, bus.sync_err, e.ese);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst            = v.rst;
    bus.mode       = v.mode;
    bus.f_valid    = v.fv;
    bus.frame_sync = v.fs;
    {bus.s2, bus.s1} = v.sel;
    bus.f          = v.f;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
    vec_no++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.mode = 1'b0;  bus.f_valid = 1'b0;  bus.frame_sync = 1'b0;
    bus.s1 = 1'b0;    bus.s2 = 1'b0;       bus.f = '0;

    // rst mode fv fs sel f     x1     x2     x3     x4     x_valid fd se
    table_v.push_back(mk(1,0,1,1,2'd0,8'hFF, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0));
    table_v.push_back(mk(1,0,1,1,2'd0,8'hFF, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0));
    table_v.push_back(mk(0,1,1,0,2'd0,8'h01, 8'h01,8'h00,8'h00,8'h00, 4'b0001,0,0));
    table_v.push_back(mk(0,1,1,0,2'd1,8'h01, 8'h01,8'h01,8'h00,8'h00, 4'b0010,0,0));
    table_v.push_back(mk(0,1,1,0,2'd2,8'h01, 8'h01,8'h01,8'h01,8'h00, 4'b0100,0,0));
    table_v.push_back(mk(0,1,1,0,2'd3,8'h01, 8'h01,8'h01,8'h01,8'h01, 4'b1000,0,0));
    table_v.push_back(mk(0,1,0,0,2'd0,8'h77, 8'h01,8'h01,8'h01,8'h01, 4'b0000,0,0));
    table_v.push_back(mk(0,0,1,1,2'd0,8'hA1, 8'hA1,8'h01,8'h01,8'h01, 4'b0001,0,0));
    table_v.push_back(mk(0,0,1,0,2'd0,8'hB2, 8'hA1,8'hB2,8'h01,8'h01, 4'b0010,0,0));
    table_v.push_back(mk(0,0,1,0,2'd0,8'hC3, 8'hA1,8'hB2,8'hC3,8'h01, 4'b0100,0,0));
    table_v.push_back(mk(0,0,1,0,2'd0,8'hD4, 8'hA1,8'hB2,8'hC3,8'hD4, 4'b1000,1,0));
    table_v.push_back(mk(0,0,1,1,2'd0,8'h11, 8'h11,8'hB2,8'hC3,8'hD4, 4'b0001,0,0));
    table_v.push_back(mk(0,0,0,1,2'd0,8'h55, 8'h11,8'hB2,8'hC3,8'hD4, 4'b0000,0,0));
    table_v.push_back(mk(0,0,1,0,2'd0,8'h22, 8'h11,8'h22,8'hC3,8'hD4, 4'b0010,0,0));
    table_v.push_back(mk(0,0,0,0,2'd0,8'h55, 8'h11,8'h22,8'hC3,8'hD4, 4'b0000,0,0));
    table_v.push_back(mk(0,0,1,0,2'd0,8'h33, 8'h11,8'h22,8'h33,8'hD4, 4'b0100,0,0));
    table_v.push_back(mk(0,0,0,1,2'd0,8'h55, 8'h11,8'h22,8'h33,8'hD4, 4'b0000,0,0));
    table_v.push_back(mk(0,0,1,0,2'd0,8'h44, 8'h11,8'h22,8'h33,8'h44, 4'b1000,1,0));

    for (int i = 0; i < table_v.size(); i++) applyStimulus(table_v[i]);

    // Early sync at slot 2 realigns onto x1, then the frame completes normally.
    applyStimulus(mk(0,0,1,1,2'd0,8'h5A, 8'h5A,8'h22,8'h33,8'h44, 4'b0001,0,0));
    applyStimulus(mk(0,0,1,0,2'd0,8'h6B, 8'h5A,8'h6B,8'h33,8'h44, 4'b0010,0,0));
    applyStimulus(mk(0,0,1,1,2'd0,8'h7C, 8'h7C,8'h6B,8'h33,8'h44, 4'b0001,0,1));
    applyStimulus(mk(0,0,1,0,2'd0,8'h8D, 8'h7C,8'h8D,8'h33,8'h44, 4'b0010,0,0));
    applyStimulus(mk(0,0,1,0,2'd0,8'h9E, 8'h7C,8'h8D,8'h9E,8'h44, 4'b0100,0,0));
    applyStimulus(mk(0,0,1,0,2'd0,8'hAF, 8'h7C,8'h8D,8'h9E,8'hAF, 4'b1000,1,0));

    // Missing sync at slot 0 drops back to HUNT; HUNT drops unsynced samples.
    applyStimulus(mk(0,0,1,0,2'd0,8'hEE, 8'h7C,8'h8D,8'h9E,8'hAF, 4'b0000,0,1));
    applyStimulus(mk(0,0,1,0,2'd0,8'hEE, 8'h7C,8'h8D,8'h9E,8'hAF, 4'b0000,0,0));
    applyStimulus(mk(0,0,1,1,2'd0,8'hC0, 8'hC0,8'h8D,8'h9E,8'hAF, 4'b0001,0,0));
    applyStimulus(mk(0,0,1,0,2'd0,8'hC1, 8'hC0,8'hC1,8'h9E,8'hAF, 4'b0010,0,0));

    // Switch to direct mid-frame: no frame_done, frame_sync ignored.
    applyStimulus(mk(0,1,1,1,2'd3,8'hD0, 8'hC0,8'hC1,8'h9E,8'hD0, 4'b1000,0,0));
    applyStimulus(mk(0,1,1,1,2'd2,8'hD1, 8'hC0,8'hC1,8'hD1,8'hD0, 4'b0100,0,0));

    // Back to TDM starts in HUNT.
    applyStimulus(mk(0,0,1,0,2'd0,8'hE0, 8'hC0,8'hC1,8'hD1,8'hD0, 4'b0000,0,0));
    applyStimulus(mk(0,0,1,1,2'd0,8'hE1, 8'hE1,8'hC1,8'hD1,8'hD0, 4'b0001,0,0));
    applyStimulus(mk(0,0,1,0,2'd0,8'hE2, 8'hE1,8'hE2,8'hD1,8'hD0, 4'b0010,0,0));

    // Reset mid-frame clears everything and returns to HUNT.
    applyStimulus(mk(1,0,1,0,2'd0,8'hFF, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0));
    applyStimulus(mk(0,0,1,0,2'd0,8'h12, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0));
    applyStimulus(mk(0,0,1,1,2'd0,8'h34, 8'h34,8'h00,8'h00,8'h00, 4'b0001,0,0));

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard drain: got %0d left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
